// File: rtl/viterbi_link_ctrl_if.sv
// Handshake/config bundle between the link controller and its encoder/channel/decoder datapath.
interface viterbi_link_ctrl_if #(parameter int FRAME_W = 8);
  logic               start_i;
  logic [FRAME_W-1:0] frame_len_i;
  logic [7:0]         err_period_i;
  logic [3:0]         err_burst_i;
  logic [1:0]         err_pattern_i;
  logic               src_bit_i;
  logic               src_req_o;
  logic               enable_encoder_o;
  logic               encoder_i_o;
  logic [1:0]         err_inj_o;
  logic               dec_bit_i;
  logic               busy_o;
  logic               done_o;
  logic [15:0]        chan_err_ct_o;
  logic [15:0]        bit_err_ct_o;

  modport master (
    input  start_i, frame_len_i, err_period_i, err_burst_i, err_pattern_i, src_bit_i, dec_bit_i,
    output src_req_o, enable_encoder_o, encoder_i_o, err_inj_o, busy_o, done_o,
    chan_err_ct_o, bit_err_ct_o
  );

  modport slave (
    output start_i, frame_len_i, err_period_i, err_burst_i, err_pattern_i, src_bit_i, dec_bit_i,
    input  src_req_o, enable_encoder_o, encoder_i_o, err_inj_o, busy_o, done_o,
    chan_err_ct_o, bit_err_ct_o
  );
endinterface

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for encoder -> channel -> Viterbi decoder: feeds data+tail, injects channel
// errors, counts post-decode mismatches. VITERBI_CTRL_PRBS_EN selects internal PRBS7 data.
module viterbi_link_ctrl #(
  parameter int FRAME_W = 8,
  parameter int TAIL    = 2,
  parameter int DEC_LAT = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_link_ctrl_if.master  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_TAIL  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int CW = 16;

  logic [2:0]         state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [FRAME_W-1:0] len_q;
  logic [7:0]         per_q, pc;
  logic [3:0]         burst_q;
  logic [1:0]         pat_q;
  logic [DEC_LAT-1:0] ln_data, ln_bit;
  logic               start_ev, data_bit, mismatch, inj_now;
  logic [16:0]        chan_sum;

  assign start_ev = (state == S_IDLE) && bus.start_i;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (bus.start_i) state_nx = (bus.frame_len_i != '0) ? S_SEND : S_TAIL;
      end
      S_SEND:  if (cnt == CW'(len_q) - CW'(1)) begin state_nx = S_TAIL;  cnt_nx = '0; end
      S_TAIL:  if (cnt == CW'(TAIL - 1))       begin state_nx = S_DRAIN; cnt_nx = '0; end
      S_DRAIN: if (cnt == CW'(DEC_LAT - 1))    begin state_nx = S_DONE;  cnt_nx = '0; end
      S_DONE:  begin state_nx = S_IDLE; cnt_nx = '0; end
      default: begin state_nx = S_IDLE; cnt_nx = '0; end
    endcase
  end

`ifdef VITERBI_CTRL_PRBS_EN
  logic [6:0] lfsr, lfsr_cur;
  // Reseed is folded into the start edge so the first SEND bit already comes from 7'h01.
  assign lfsr_cur = (state == S_IDLE) ? 7'h01 : lfsr;
  assign data_bit = lfsr_cur[6];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    lfsr <= 7'h01;
    else if (state_nx == S_SEND) lfsr <= {lfsr_cur[5:0], lfsr_cur[6] ^ lfsr_cur[5]};
  end
`else
  assign data_bit = bus.src_bit_i;
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  // src_req_o marks the cycle carrying the bit taken at its opening edge; the source then advances.
  assign inj_now  = bus.enable_encoder_o && (per_q != 8'd0) && (pc < {4'd0, burst_q});
  assign mismatch = ln_data[DEC_LAT-1] && (ln_bit[DEC_LAT-1] != bus.dec_bit_i);
  assign chan_sum = {1'b0, bus.chan_err_ct_o} + 17'(bus.err_inj_o[0]) + 17'(bus.err_inj_o[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      len_q                <= '0;
      per_q                <= '0;
      burst_q              <= '0;
      pat_q                <= '0;
      pc                   <= '0;
      ln_data              <= '0;
      ln_bit               <= '0;
      bus.src_req_o        <= 1'b0;
      bus.enable_encoder_o <= 1'b0;
      bus.encoder_i_o      <= 1'b0;
      bus.err_inj_o        <= 2'b00;
      bus.busy_o           <= 1'b0;
      bus.done_o           <= 1'b0;
      bus.chan_err_ct_o    <= '0;
      bus.bit_err_ct_o     <= '0;
    end else begin
      state                <= state_nx;
      cnt                  <= cnt_nx;
      bus.src_req_o        <= (state_nx == S_SEND);
      bus.enable_encoder_o <= (state_nx == S_SEND) || (state_nx == S_TAIL);
      bus.encoder_i_o      <= (state_nx == S_SEND) && data_bit;
      bus.busy_o           <= (state_nx != S_IDLE);
      bus.done_o           <= (state_nx == S_DONE);
      bus.err_inj_o        <= inj_now ? pat_q : 2'b00;

      ln_data[0] <= bus.src_req_o;
      ln_bit[0]  <= bus.encoder_i_o;
      for (int i = 1; i < DEC_LAT; i++) begin
        ln_data[i] <= ln_data[i-1];
        ln_bit[i]  <= ln_bit[i-1];
      end

      if (start_ev) begin
        len_q             <= bus.frame_len_i;
        per_q             <= bus.err_period_i;
        burst_q           <= bus.err_burst_i;
        pat_q             <= bus.err_pattern_i;
        pc                <= '0;
        bus.chan_err_ct_o <= '0;
        bus.bit_err_ct_o  <= '0;
      end else begin
        if (bus.enable_encoder_o && per_q != 8'd0)
          pc <= (pc == per_q - 8'd1) ? 8'd0 : pc + 8'd1;
        bus.chan_err_ct_o <= chan_sum[16] ? 16'hFFFF : chan_sum[15:0];
        if (mismatch && bus.bit_err_ct_o != 16'hFFFF)
          bus.bit_err_ct_o <= bus.bit_err_ct_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Self-checking bench for viterbi_link_ctrl: source/decoder models plus per-scenario scoreboards.
module tb_viterbi_link_ctrl;
  localparam int FRAME_W = 8;
  localparam int TAIL    = 2;
  localparam int DEC_LAT = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_link_ctrl_if #(.FRAME_W(FRAME_W)) bus();
  viterbi_link_ctrl #(.FRAME_W(FRAME_W), .TAIL(TAIL), .DEC_LAT(DEC_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int err = 0;
  int chk = 0;

  // Source model: show-ahead bit, advances after each cycle that shows src_req_o.
  bit       src_arr[256];
  logic [7:0] src_idx = '0;
  assign bus.src_bit_i = src_arr[src_idx];
  always @(posedge clk) begin
    #1;
    if (!bus.busy_o) src_idx = '0;
    else if (bus.src_req_o) src_idx = src_idx + 8'd1;
  end

  // Ideal decoder: replays encoder input DEC_LAT cycles later, optionally flipping one enabled index.
  logic [DEC_LAT-1:0] dpipe = '0;
  int tpipe[DEC_LAT];
  int en_ctr = 0;
  int flip_idx = -2;
  always @(posedge clk) begin
    dpipe    <= {dpipe[DEC_LAT-2:0], bus.encoder_i_o};
    tpipe[0] <= bus.enable_encoder_o ? en_ctr : -1;
    for (int i = 1; i < DEC_LAT; i++) tpipe[i] <= tpipe[i-1];
    en_ctr   <= !bus.busy_o ? 0 : (bus.enable_encoder_o ? en_ctr + 1 : en_ctr);
  end
  assign bus.dec_bit_i = dpipe[DEC_LAT-1] ^ (tpipe[DEC_LAT-1] == flip_idx);

  bit   exp_q[$];
  logic obs_enc[$];
  logic [1:0] exp_inj[$];
  logic [1:0] obs_inj[$];
  int n_req, n_en, n_done, done_edge;
  bit timed_out;

  task automatic load_frame(input int len);
    logic [6:0] lf = 7'h01;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      src_arr[i] = 1'($urandom);
`ifdef VITERBI_CTRL_PRBS_EN
      exp_q.push_back(lf[6]);
      lf = {lf[5:0], lf[6] ^ lf[5]};
`else
      exp_q.push_back(src_arr[i]);
`endif
    end
  endtask

  // Drives one frame and collects what the DUT produced; comparisons live in the test tasks.
  task automatic run_frame(input int len, input int per, input int burst, input int pat,
                           input bit pulse_busy);
    int cyc;
    bit prev_en;
    obs_enc.delete(); obs_inj.delete();
    n_req = 0; n_en = 0; n_done = 0; done_edge = -1; prev_en = 0;
    @(negedge clk);
    bus.frame_len_i   = FRAME_W'(len);
    bus.err_period_i  = 8'(per);
    bus.err_burst_i   = 4'(burst);
    bus.err_pattern_i = 2'(pat);
    bus.start_i       = 1'b1;
    @(negedge clk);
    bus.start_i       = 1'b0;
    bus.frame_len_i   = FRAME_W'(len + 5);
    bus.err_period_i  = 8'd3;
    bus.err_pattern_i = 2'b11;
    cyc = 1;
    while (cyc < 400) begin
      if (prev_en) obs_inj.push_back(bus.err_inj_o);
      prev_en = bus.enable_encoder_o;
      if (bus.src_req_o) begin n_req++; obs_enc.push_back(bus.encoder_i_o); end
      if (bus.enable_encoder_o) n_en++;
      if (bus.done_o) begin n_done++; if (done_edge < 0) done_edge = cyc - 1; end
      bus.start_i = (pulse_busy && cyc == 2);
      if (done_edge >= 0 && cyc > done_edge + 3) break;
      @(negedge clk);
      cyc++;
    end
    bus.start_i = 1'b0;
    timed_out = (done_edge < 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk++; if ({bus.busy_o, bus.done_o, bus.src_req_o, bus.enable_encoder_o, bus.encoder_i_o, bus.err_inj_o} !== 7'd0) begin
      err++; $display("FAIL reset_outs got=%b exp=0", {bus.busy_o, bus.done_o, bus.src_req_o, bus.enable_encoder_o, bus.encoder_i_o, bus.err_inj_o}); end
    chk++; if ({bus.chan_err_ct_o, bus.bit_err_ct_o} !== 32'd0) begin
      err++; $display("FAIL reset_cts got=%h exp=0", {bus.chan_err_ct_o, bus.bit_err_ct_o}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal();
    load_frame(16);
    run_frame(16, 0, 0, 0, 0);
    chk++; if (timed_out) begin err++; $display("FAIL ideal_timeout got=none exp=done"); end
    chk++; if (n_req !== 16) begin err++; $display("FAIL ideal_src_req got=%0d exp=16", n_req); end
    chk++; if (n_en !== 18) begin err++; $display("FAIL ideal_enable got=%0d exp=18", n_en); end
    chk++; if (done_edge !== 38) begin err++; $display("FAIL ideal_done_lat got=%0d exp=38", done_edge); end
    chk++; if (n_done !== 1) begin err++; $display("FAIL ideal_done_width got=%0d exp=1", n_done); end
    while (exp_q.size() > 0 && obs_enc.size() > 0) begin
      bit e; logic o;
      e = exp_q.pop_front(); o = obs_enc.pop_front();
      chk++; if (o !== e) begin err++; $display("FAIL ideal_enc_bit got=%b exp=%b", o, e); end
    end
    chk++; if (exp_q.size() + obs_enc.size() != 0) begin
      err++; $display("FAIL ideal_enc_count got=%0d exp=0 leftover", exp_q.size() + obs_enc.size()); end
    foreach (obs_inj[i]) begin
      chk++; if (obs_inj[i] !== 2'b00) begin err++; $display("FAIL ideal_inj idx=%0d got=%b exp=00", i, obs_inj[i]); end
    end
    chk++; if (bus.chan_err_ct_o !== 16'd0) begin err++; $display("FAIL ideal_chan got=%0d exp=0", bus.chan_err_ct_o); end
    chk++; if (bus.bit_err_ct_o !== 16'd0) begin err++; $display("FAIL ideal_bit got=%0d exp=0", bus.bit_err_ct_o); end
  endtask

  task automatic test_inject();
    load_frame(32);
    exp_inj.delete();
    for (int i = 0; i < 32 + TAIL; i++) exp_inj.push_back(((i % 8) < 2) ? 2'b10 : 2'b00);
    run_frame(32, 8, 2, 2'b10, 0);
    chk++; if (timed_out) begin err++; $display("FAIL inj_timeout got=none exp=done"); end
    chk++; if (obs_inj.size() !== exp_inj.size()) begin
      err++; $display("FAIL inj_count got=%0d exp=%0d", obs_inj.size(), exp_inj.size()); end
    for (int i = 0; exp_inj.size() > 0 && obs_inj.size() > 0; i++) begin
      logic [1:0] e, o;
      e = exp_inj.pop_front(); o = obs_inj.pop_front();
      chk++; if (o !== e) begin err++; $display("FAIL inj_mask idx=%0d got=%b exp=%b", i, o, e); end
    end
    chk++; if (bus.chan_err_ct_o !== 16'd10) begin err++; $display("FAIL inj_chan got=%0d exp=10", bus.chan_err_ct_o); end
    chk++; if (bus.bit_err_ct_o !== 16'd0) begin err++; $display("FAIL inj_bit got=%0d exp=0", bus.bit_err_ct_o); end
    repeat (5) @(negedge clk);
    chk++; if (bus.chan_err_ct_o !== 16'd10 || bus.busy_o !== 1'b0) begin
      err++; $display("FAIL inj_hold got=%0d/%b exp=10/0", bus.chan_err_ct_o, bus.busy_o); end
  endtask

  task automatic test_bit_flip();
    load_frame(32);
    flip_idx = 5;
    run_frame(32, 8, 2, 2'b10, 0);
    chk++; if (bus.bit_err_ct_o !== 16'd1) begin err++; $display("FAIL flip_data got=%0d exp=1", bus.bit_err_ct_o); end
    chk++; if (bus.chan_err_ct_o !== 16'd10) begin err++; $display("FAIL flip_chan got=%0d exp=10", bus.chan_err_ct_o); end
    load_frame(32);
    flip_idx = 32;
    run_frame(32, 8, 2, 2'b10, 0);
    chk++; if (bus.bit_err_ct_o !== 16'd0) begin err++; $display("FAIL flip_tail got=%0d exp=0", bus.bit_err_ct_o); end
    flip_idx = -2;
  endtask

  task automatic test_zero_len();
    load_frame(0);
    run_frame(0, 1, 1, 2'b01, 1);
    chk++; if (timed_out) begin err++; $display("FAIL zero_timeout got=none exp=done"); end
    chk++; if (n_req !== 0) begin err++; $display("FAIL zero_src_req got=%0d exp=0", n_req); end
    chk++; if (n_en !== TAIL) begin err++; $display("FAIL zero_enable got=%0d exp=%0d", n_en, TAIL); end
    chk++; if (done_edge !== TAIL + DEC_LAT) begin
      err++; $display("FAIL zero_done_lat got=%0d exp=%0d", done_edge, TAIL + DEC_LAT); end
    chk++; if (n_done !== 1) begin err++; $display("FAIL zero_done_width got=%0d exp=1", n_done); end
    chk++; if (bus.chan_err_ct_o !== 16'd2 || bus.bit_err_ct_o !== 16'd0) begin
      err++; $display("FAIL zero_cts got=%0d/%0d exp=2/0", bus.chan_err_ct_o, bus.bit_err_ct_o); end
    repeat (4) @(negedge clk);
    chk++; if (bus.busy_o !== 1'b0) begin err++; $display("FAIL zero_busy_pulse got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_reset_midrun();
    load_frame(32);
    @(negedge clk);
    bus.frame_len_i = 8'd32; bus.err_period_i = 8'd1; bus.err_burst_i = 4'd1;
    bus.err_pattern_i = 2'b11; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk++; if (bus.chan_err_ct_o !== 16'd16) begin err++; $display("FAIL mid_chan got=%0d exp=16", bus.chan_err_ct_o); end
    #2 rst = 1'b0;
    #1;
    chk++; if ({bus.busy_o, bus.done_o, bus.src_req_o, bus.enable_encoder_o, bus.encoder_i_o, bus.err_inj_o} !== 7'd0) begin
      err++; $display("FAIL mid_outs got=%b exp=0", {bus.busy_o, bus.done_o, bus.src_req_o, bus.enable_encoder_o, bus.encoder_i_o, bus.err_inj_o}); end
    chk++; if ({bus.chan_err_ct_o, bus.bit_err_ct_o} !== 32'd0) begin
      err++; $display("FAIL mid_cts got=%h exp=0", {bus.chan_err_ct_o, bus.bit_err_ct_o}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) n_done++;
    end
    chk++; if (n_done !== 0) begin err++; $display("FAIL mid_no_done got=%0d exp=0", n_done); end
  endtask

`ifdef VITERBI_CTRL_PRBS_EN
  task automatic test_prbs();
    load_frame(7);
    run_frame(7, 0, 0, 0, 0);
    chk++; if (n_req !== 7) begin err++; $display("FAIL prbs_src_req got=%0d exp=7", n_req); end
    for (int i = 0; exp_q.size() > 0 && obs_enc.size() > 0; i++) begin
      bit e; logic o;
      e = exp_q.pop_front(); o = obs_enc.pop_front();
      chk++; if (o !== e) begin err++; $display("FAIL prbs_bit idx=%0d got=%b exp=%b", i, o, e); end
    end
  endtask
`endif

  initial begin
    bus.start_i = 1'b0; bus.frame_len_i = '0; bus.err_period_i = '0;
    bus.err_burst_i = '0; bus.err_pattern_i = '0;
    test_reset();
    test_ideal();
    test_inject();
    test_bit_flip();
    test_zero_len();
`ifdef VITERBI_CTRL_PRBS_EN
    test_prbs();
`endif
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
